rp_prune_ctrl: RTL and testbench

Parametrised pruning controller for the random-projection encoder. It evaluates accumulator outputs from the RP mux one chunk of `DIMS_PER_CC` dimensions per handshake. It builds a `HV_DIM`-bit keep mask over `HV_DIM/DIMS_PER_CC` chunks and commits that mask atomically to a double-buffered active copy. The encoder reads the active copy chunk-by-chunk as per-dimension enables, so inference never sees a half-built mask.

---
 rtl/rp_pkg.sv | 21 ++
 rtl/rp_chunk_eval.sv | 44 ++++
 rtl/rp_prune_ctrl.sv | 105 ++++++++++
 tb/tb_rp_prune_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_pkg.sv
// Shared types and default sizing for the random-projection encoder.
package rp_pkg;

    localparam int RP_HV_DIM      = 4096;
    localparam int RP_DIMS_PER_CC = 1024;
    localparam int RP_ACC_W       = 26;

    // Codes 2 and 3 both behave as BYPASS.
    typedef enum logic [1:0] {
        EXTREME   = 2'd0,
        THRESHOLD = 2'd1,
        BYPASS    = 2'd2
    } rp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } rp_prune_state_e;

endpackage

// File: rtl/rp_chunk_eval.sv
// Combinational prune evaluation of one chunk: per-dimension keep bits and
// the number of dimensions pruned in the chunk.
module rp_chunk_eval
    import rp_pkg::*;
#(
    parameter int DIMS_PER_CC = RP_DIMS_PER_CC,
    parameter int ACC_W       = RP_ACC_W
) (
    input  logic [DIMS_PER_CC*ACC_W-1:0]     data,
    input  logic [1:0]                       mode,
    input  logic [ACC_W-1:0]                 lo_thr,
    input  logic [ACC_W-1:0]                 hi_thr,
    output logic [DIMS_PER_CC-1:0]           keep,
    output logic [$clog2(DIMS_PER_CC+1)-1:0] pruned
);

    localparam int PC_W = $clog2(DIMS_PER_CC + 1);

    for (genvar g = 0; g < DIMS_PER_CC; g++) begin : g_dim
        logic [ACC_W-1:0] v;
        logic             prune;

        assign v = data[g*ACC_W +: ACC_W];

        // lo_thr > hi_thr needs no special case: every v then fails one bound.
        always_comb begin
            case (mode)
                EXTREME:   prune = (v == '0) || (v == '1);
                THRESHOLD: prune = (v < lo_thr) || (v > hi_thr);
                default:   prune = 1'b0;
            endcase
        end

        assign keep[g] = ~prune;
    end

    always_comb begin
        pruned = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            pruned = pruned + PC_W'(~keep[i]);
        end
    end

endmodule

// File: rtl/rp_prune_ctrl.sv
// Pruning controller: collects per-chunk keep bits into a shadow mask and
// swaps it into the active mask in a single COMMIT cycle.
module rp_prune_ctrl
    import rp_pkg::*;
#(
    parameter int   HV_DIM      = RP_HV_DIM,
    parameter int   DIMS_PER_CC = RP_DIMS_PER_CC,
    parameter int   ACC_W       = RP_ACC_W,
    localparam int  SEQ         = HV_DIM / DIMS_PER_CC,
    localparam int  IDX_W       = (SEQ > 1) ? $clog2(SEQ) : 1,
    localparam int  CNT_W       = $clog2(HV_DIM + 1)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [ACC_W-1:0]             lo_thr,
    input  logic [ACC_W-1:0]             hi_thr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIMS_PER_CC*ACC_W-1:0] in_data,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic [DIMS_PER_CC-1:0]       enable_signal,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             pruned_count
);

    localparam int PC_W = $clog2(DIMS_PER_CC + 1);

    typedef struct packed {
        logic [1:0]       mode;
        logic [ACC_W-1:0] lo_thr;
        logic [ACC_W-1:0] hi_thr;
    } cfg_t;

    rp_prune_state_e                 state;
    cfg_t                            cfg;
    logic [IDX_W-1:0]                idx;
    logic [CNT_W-1:0]                cnt_acc;
    logic [SEQ-1:0][DIMS_PER_CC-1:0] shadow;
    logic [SEQ-1:0][DIMS_PER_CC-1:0] active;
    logic [DIMS_PER_CC-1:0]          keep;
    logic [PC_W-1:0]                 chunk_pruned;
    logic [DIMS_PER_CC-1:0]          rd_word;
    logic                            last;

    rp_chunk_eval #(
        .DIMS_PER_CC (DIMS_PER_CC),
        .ACC_W       (ACC_W)
    ) u_eval (
        .data   (in_data),
        .mode   (cfg.mode),
        .lo_thr (cfg.lo_thr),
        .hi_thr (cfg.hi_thr),
        .keep   (keep),
        .pruned (chunk_pruned)
    );

    assign in_ready = (state == ST_COLLECT);
    assign busy     = (state != ST_IDLE);
    assign last     = (idx == IDX_W'(SEQ - 1));

    // Indices past the last chunk (non power-of-two SEQ) read as all-enabled.
    if (SEQ == (1 << IDX_W)) begin : g_rd_full
        assign rd_word = active[rd_idx];
    end else begin : g_rd_part
        assign rd_word = (rd_idx < IDX_W'(SEQ)) ? active[rd_idx] : '1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= ST_IDLE;
            cfg           <= '0;
            idx           <= '0;
            cnt_acc       <= '0;
            shadow        <= '1;
            active        <= '1;
            enable_signal <= '1;
            done          <= 1'b0;
            pruned_count  <= '0;
        end else begin
            done          <= 1'b0;
            enable_signal <= rd_word;
            // start wins over a same-cycle accept; COMMIT cannot be interrupted.
            if (start && state != ST_COMMIT) begin
                state   <= ST_COLLECT;
                idx     <= '0;
                cnt_acc <= '0;
                cfg     <= {mode, lo_thr, hi_thr};
            end else if (state == ST_COMMIT) begin
                active       <= shadow;
                pruned_count <= cnt_acc;
                done         <= 1'b1;
                state        <= ST_IDLE;
            end else if (in_valid && in_ready) begin
                shadow[idx] <= keep;
                cnt_acc     <= cnt_acc + CNT_W'(chunk_pruned);
                idx         <= idx + 1'b1;
                if (last) state <= ST_COMMIT;
            end
        end
    end

endmodule

// File: tb/tb_rp_prune_ctrl.sv
// Randomised self-checking bench for rp_prune_ctrl against a per-dimension rule model.
module tb_rp_prune_ctrl;

    localparam int D = 4, W = 8, SEQ = 4;

    logic           clk = 1'b0, nrst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [1:0]     mode = '0;
    logic [W-1:0]   lo_thr = '0, hi_thr = '0;
    logic [D*W-1:0] in_data = '0;
    logic [1:0]     rd_idx = '0;
    logic           in_ready, busy, done;
    logic [D-1:0]   enable_signal;
    logic [4:0]     pruned_count;

    int n_chk = 0, n_fail = 0;

    logic [D*W-1:0] chunk_buf [SEQ];
    logic [D-1:0]   m_active  [SEQ];
    logic [D-1:0]   p_keep    [SEQ];
    int             p_cnt;

    always #5 clk = ~clk;

    rp_prune_ctrl #(.HV_DIM(16), .DIMS_PER_CC(4), .ACC_W(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .mode(mode), .lo_thr(lo_thr), .hi_thr(hi_thr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rd_idx(rd_idx),
        .enable_signal(enable_signal), .busy(busy), .done(done), .pruned_count(pruned_count)
    );

    function automatic bit is_pruned(logic [1:0] m, logic [7:0] lo, logic [7:0] hi, logic [7:0] v);
        if (m == 2'd0) return (v == 8'h00) || (v == 8'hFF);
        if (m == 2'd1) return (v < lo) || (v > hi);
        return 1'b0;
    endfunction

    function automatic void predict(logic [1:0] m, logic [7:0] lo, logic [7:0] hi);
        bit pr;
        p_cnt = 0;
        for (int c = 0; c < SEQ; c++)
            for (int d = 0; d < D; d++) begin
                pr = is_pruned(m, lo, hi, chunk_buf[c][d*W +: W]);
                p_keep[c][d] = !pr;
                p_cnt += int'(pr);
            end
    endfunction

    function automatic logic [7:0] pick(logic [7:0] lo, logic [7:0] hi);
        case ($urandom_range(0, 6))
            0: return 8'h00;
            1: return 8'hFF;
            2: return lo;
            3: return hi;
            4: return lo - 8'd1;
            5: return hi + 8'd1;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic void fill_rand(logic [7:0] lo, logic [7:0] hi);
        for (int c = 0; c < SEQ; c++)
            for (int d = 0; d < D; d++) chunk_buf[c][d*W +: W] = pick(lo, hi);
    endfunction

    task automatic begin_pass(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi);
        start = 1'b1; mode = m; lo_thr = lo; hi_thr = hi;
        @(negedge clk);
        start = 1'b0; mode = 2'($urandom); lo_thr = 8'($urandom); hi_thr = 8'($urandom);
    endtask

    task automatic send_chunks(input int first, input int last, input bit gaps, output bit to);
        int  c = first;
        int  budget = 200;
        bit  acc;
        to = 1'b0;
        while (c <= last) begin
            if (budget == 0) begin to = 1'b1; break; end
            budget--;
            if (gaps && $urandom_range(0, 2) == 0) begin in_valid = 1'b0; in_data = $urandom; end
            else begin in_valid = 1'b1; in_data = chunk_buf[c]; end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 10; i++) begin
            if (done) begin cyc = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_full(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                            input bit gaps, output bit to, output int cyc);
        begin_pass(m, lo, hi);
        send_chunks(0, SEQ - 1, gaps, to);
        predict(m, lo, hi);
        wait_done(cyc);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl got rdy=%b busy=%b done=%b want 0 0 0", in_ready, busy, done); end
        n_chk++; if (pruned_count !== 5'd0) begin
            n_fail++; $display("FAIL reset_count got %0d want 0", pruned_count); end
        nrst = 1'b1;
        for (int r = 0; r < SEQ; r++) begin
            m_active[r] = 4'hF;
            rd_idx = 2'(r);
            @(negedge clk);
            n_chk++; if (enable_signal !== 4'hF) begin
                n_fail++; $display("FAIL reset_mask[%0d] got %b want 1111", r, enable_signal); end
        end
    endtask

    task automatic test_modes();
        logic [1:0] m; logic [7:0] lo, hi; bit to; int cyc;
        for (int k = 0; k < 10; k++) begin
            case (k)
                0: begin m = 2'd0; lo = 8'h00; hi = 8'h00; chunk_buf[0] = 32'h3412FF00;
                         for (int c = 1; c < SEQ; c++) chunk_buf[c] = 32'h55555555; end
                1: begin m = 2'd1; lo = 8'h10; hi = 8'hE0;
                         for (int c = 0; c < SEQ; c++) chunk_buf[c] = 32'hE1E0100F; end
                2: begin m = 2'd1; lo = 8'h80; hi = 8'h20; fill_rand(lo, hi); end
                3: begin m = 2'd2; lo = 8'h40; hi = 8'h50; fill_rand(lo, hi); end
                4: begin m = 2'd3; lo = 8'h40; hi = 8'h50; fill_rand(lo, hi); end
                default: begin m = 2'($urandom_range(0, 1)); lo = 8'($urandom_range(0, 127));
                               hi = 8'($urandom_range(64, 255)); fill_rand(lo, hi); end
            endcase
            run_full(m, lo, hi, 1'b0, to, cyc);
            n_chk++; if (to || cyc != 1) begin
                n_fail++; $display("FAIL modes_done k=%0d got latency %0d timeout %0d want 1 0", k, cyc, to); end
            n_chk++; if (pruned_count !== 5'(p_cnt)) begin
                n_fail++; $display("FAIL modes_count k=%0d got %0d want %0d", k, pruned_count, p_cnt); end
            for (int r = 0; r < SEQ; r++) begin
                m_active[r] = p_keep[r];
                rd_idx = 2'(r);
                @(negedge clk);
                n_chk++; if (enable_signal !== m_active[r]) begin
                    n_fail++; $display("FAIL modes_mask[%0d] k=%0d got %b want %b", r, k, enable_signal, m_active[r]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] lo, hi; logic [1:0] m; bit to;
        for (int k = 0; k < 3; k++) begin
            m = 2'($urandom_range(0, 1)); lo = 8'($urandom_range(0, 100)); hi = 8'($urandom_range(120, 255));
            fill_rand(lo, hi);
            rd_idx = 2'd0;
            @(negedge clk);
            begin_pass(m, lo, hi);
            send_chunks(0, SEQ - 1, 1'b1, to);
            predict(m, lo, hi);
            n_chk++; if (to || done !== 1'b0 || busy !== 1'b1 || enable_signal !== m_active[0]) begin
                n_fail++; $display("FAIL stall_commit_cyc to=%0d got done=%b busy=%b en=%b want 0 1 %b",
                                   to, done, busy, enable_signal, m_active[0]); end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_chk++; if (done !== 1'b1 || busy !== 1'b0 || enable_signal !== m_active[0]) begin
                n_fail++; $display("FAIL stall_done_cyc got done=%b busy=%b en=%b want 1 0 %b",
                                   done, busy, enable_signal, m_active[0]); end
            n_chk++; if (pruned_count !== 5'(p_cnt)) begin
                n_fail++; $display("FAIL stall_count got %0d want %0d", pruned_count, p_cnt); end
            @(negedge clk);
            n_chk++; if (done !== 1'b0 || enable_signal !== p_keep[0]) begin
                n_fail++; $display("FAIL stall_after got done=%b en=%b want 0 %b", done, enable_signal, p_keep[0]); end
            for (int r = 0; r < SEQ; r++) begin
                m_active[r] = p_keep[r];
                rd_idx = 2'(r);
                @(negedge clk);
                n_chk++; if (enable_signal !== m_active[r]) begin
                    n_fail++; $display("FAIL stall_mask[%0d] got %b want %b", r, enable_signal, m_active[r]); end
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] lo, hi; bit to; int cyc;
        for (int c = 0; c < SEQ; c++) chunk_buf[c] = '0;
        begin_pass(2'd0, 8'h00, 8'h00);
        send_chunks(0, 1, 1'b0, to);
        lo = 8'($urandom_range(0, 100)); hi = 8'($urandom_range(120, 255));
        start = 1'b1; in_valid = 1'b1; in_data = '0; mode = 2'd1; lo_thr = lo; hi_thr = hi;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        n_chk++; if (to || busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL restart_state to=%0d got busy=%b rdy=%b want 1 1", to, busy, in_ready); end
        fill_rand(lo, hi);
        send_chunks(0, SEQ - 1, 1'b1, to);
        predict(2'd1, lo, hi);
        wait_done(cyc);
        n_chk++; if (to || cyc != 1) begin
            n_fail++; $display("FAIL restart_done got latency %0d timeout %0d want 1 0", cyc, to); end
        n_chk++; if (pruned_count !== 5'(p_cnt)) begin
            n_fail++; $display("FAIL restart_count got %0d want %0d", pruned_count, p_cnt); end
        for (int r = 0; r < SEQ; r++) begin
            m_active[r] = p_keep[r];
            rd_idx = 2'(r);
            @(negedge clk);
            n_chk++; if (enable_signal !== m_active[r]) begin
                n_fail++; $display("FAIL restart_mask[%0d] got %b want %b", r, enable_signal, m_active[r]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] m; logic [7:0] lo, hi; bit to; int cyc; int r;
        r = $urandom_range(0, SEQ - 1);
        rd_idx = 2'(r);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            m = 2'($urandom); lo = 8'($urandom_range(0, 127)); hi = 8'($urandom_range(100, 255));
            fill_rand(lo, hi);
            begin_pass(m, lo, hi);
            n_chk++; if (enable_signal !== m_active[r]) begin
                n_fail++; $display("FAIL b2b_mask k=%0d idx=%0d got %b want %b", k, r, enable_signal, m_active[r]); end
            send_chunks(0, SEQ - 1, 1'b1, to);
            predict(m, lo, hi);
            wait_done(cyc);
            n_chk++; if (to || cyc != 1) begin
                n_fail++; $display("FAIL b2b_done k=%0d got latency %0d timeout %0d want 1 0", k, cyc, to); end
            n_chk++; if (pruned_count !== 5'(p_cnt)) begin
                n_fail++; $display("FAIL b2b_count k=%0d got %0d want %0d", k, pruned_count, p_cnt); end
            for (int i = 0; i < SEQ; i++) m_active[i] = p_keep[i];
            r = $urandom_range(0, SEQ - 1);
            rd_idx = 2'(r);
        end
        @(negedge clk);
        n_chk++; if (enable_signal !== m_active[r]) begin
            n_fail++; $display("FAIL b2b_final idx=%0d got %b want %b", r, enable_signal, m_active[r]); end
    endtask

    task automatic test_mid_reset();
        bit to; int cyc;
        for (int c = 0; c < SEQ; c++) chunk_buf[c] = '0;
        run_full(2'd0, 8'h00, 8'h00, 1'b0, to, cyc);
        n_chk++; if (to || cyc != 1 || pruned_count !== 5'd16) begin
            n_fail++; $display("FAIL mreset_setup got latency %0d count %0d want 1 16", cyc, pruned_count); end
        fill_rand(8'h20, 8'hC0);
        begin_pass(2'd1, 8'h20, 8'hC0);
        send_chunks(0, 2, 1'b0, to);
        #2 nrst = 1'b0;
        #1;
        n_chk++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pruned_count !== 5'd0) begin
            n_fail++; $display("FAIL mreset_ctl got rdy=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                               in_ready, busy, done, pruned_count); end
        n_chk++; if (enable_signal !== 4'hF) begin
            n_fail++; $display("FAIL mreset_en got %b want 1111", enable_signal); end
        @(negedge clk);
        nrst = 1'b1;
        for (int r = 0; r < SEQ; r++) begin
            m_active[r] = 4'hF;
            rd_idx = 2'(r);
            @(negedge clk);
            n_chk++; if (enable_signal !== 4'hF || busy !== 1'b0) begin
                n_fail++; $display("FAIL mreset_mask[%0d] got %b busy=%b want 1111 0", r, enable_signal, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stall();
        test_restart();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
